// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M multiply/divide responder sitting behind the execute stage.
// Takes one request at a time, works on it radix-2 (one bit per cycle), and
// returns the result together with the request tag.
//
// Optional feature macro: RVM_MUL_EN
//   defined   : funct3 0xx runs MUL/MULH/MULHSU/MULHU through a shift-add
//               multiplier that shares the divider's 2*XLEN accumulator.
//   undefined : funct3 0xx is answered in one cycle with resp_err=1 and a zero
//               result; no multiplier logic is built.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  request handshake (ready only in IDLE and not flushing)
//   req_func             RV funct3 (1xx divide/remainder, 0xx multiply)
//   req_a, req_b         rs1 / rs2 operands
//   req_tag              opaque tag, echoed on resp_tag
//   flush                abort the op in flight; no response is produced
//   resp_valid/ready     response handshake, result held until accepted
//   resp_result          result word
//   resp_tag             tag of the op
//   resp_err             unsupported funct3 (result forced to zero)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request
// CALC  | iterating, one bit per cycle, cnt = 0..XLEN-1
// DONE  | result presented, waiting for resp_ready
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_func,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_step;
  logic [XLEN-1:0]   opnd;
  logic              neg_q;
  logic              rem_q;
`ifdef RVM_MUL_EN
  logic              mul_q;
  logic              mul_hi_q;
`endif

  logic            accept;
  logic            sa, sb;
  logic            a_sgn, b_sgn, neg_req;
  logic            unsup, div_zero, div_ovf, short_op;
  logic [XLEN-1:0] a_mag, b_mag, short_res, fix_res;

  assign req_ready  = (state == IDLE) && !flush;
  assign resp_valid = (state == DONE);
  assign accept     = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Request decode: operand signedness and sign of the final result.
  // ---------------------------------------------------------------------------
  assign sa = req_a[XLEN-1];
  assign sb = req_b[XLEN-1];

  always_comb begin
    a_sgn   = 1'b0;
    b_sgn   = 1'b0;
    neg_req = 1'b0;
    case (req_func)
      3'b100: begin a_sgn = 1'b1; b_sgn = 1'b1; neg_req = sa ^ sb; end
      3'b110: begin a_sgn = 1'b1; b_sgn = 1'b1; neg_req = sa;      end
`ifdef RVM_MUL_EN
      3'b001: begin a_sgn = 1'b1; b_sgn = 1'b1; neg_req = sa ^ sb; end
      3'b010: begin a_sgn = 1'b1;               neg_req = sa;      end
`endif
      default: ;
    endcase
  end

  // INT_MIN maps onto itself, which is exactly its magnitude read unsigned.
  assign a_mag = (a_sgn && sa) ? (~req_a + 1'b1) : req_a;
  assign b_mag = (b_sgn && sb) ? (~req_b + 1'b1) : req_b;

`ifdef RVM_MUL_EN
  assign unsup = 1'b0;
`else
  assign unsup = !req_func[2];
`endif

  assign div_zero = req_func[2] && (req_b == '0);
  assign div_ovf  = req_func[2] && !req_func[0] && (req_a == INT_MIN) && (req_b == '1);
  assign short_op = unsup || div_zero || div_ovf;

  always_comb begin
    short_res = '0;
    if (div_zero)
      short_res = req_func[1] ? req_a : '1;
    else if (div_ovf)
      short_res = req_func[1] ? '0 : INT_MIN;
  end

  // ---------------------------------------------------------------------------
  // One iteration step on the shared accumulator.
  // Divide: acc = {remainder, dividend/quotient}, restoring subtract.
  // Multiply: acc = {partial product, multiplier}, add-and-shift right.
  // ---------------------------------------------------------------------------
  logic [XLEN:0]     div_hi, div_diff;
  logic [2*XLEN-1:0] div_next;

  assign div_hi   = acc[2*XLEN-1:XLEN-1];
  assign div_diff = div_hi - {1'b0, opnd};
  assign div_next = div_diff[XLEN] ? {div_hi[XLEN-1:0],   acc[XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

`ifdef RVM_MUL_EN
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [2*XLEN-1:0] prod_fix;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
                    {1'b0, (acc[0] ? opnd : {XLEN{1'b0}})};
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign acc_step = mul_q ? mul_next : div_next;
  assign prod_fix = neg_q ? (~acc_step + 1'b1) : acc_step;
`else
  assign acc_step = div_next;
`endif

  // Sign fixup applied to the value produced by the final iteration.
  logic [XLEN-1:0] div_word;
  assign div_word = rem_q ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];

  always_comb begin
    fix_res = neg_q ? (~div_word + 1'b1) : div_word;
`ifdef RVM_MUL_EN
    if (mul_q)
      fix_res = mul_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)           state_nxt = short_op ? DONE : CALC;
      CALC: if (cnt == CNT_LAST)  state_nxt = DONE;
      DONE: if (resp_ready)       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      neg_q       <= 1'b0;
      rem_q       <= 1'b0;
`ifdef RVM_MUL_EN
      mul_q       <= 1'b0;
      mul_hi_q    <= 1'b0;
`endif
      resp_result <= '0;
      resp_tag    <= '0;
      resp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            resp_tag <= req_tag;
            resp_err <= unsup;
            neg_q    <= neg_req;
            rem_q    <= req_func[1];
`ifdef RVM_MUL_EN
            mul_q    <= !req_func[2];
            mul_hi_q <= (req_func[1:0] != 2'b00);
`endif
            if (short_op) begin
              resp_result <= short_res;
            end else begin
`ifdef RVM_MUL_EN
              if (!req_func[2]) begin
                acc  <= {{XLEN{1'b0}}, b_mag};
                opnd <= a_mag;
              end else
`endif
              begin
                acc  <= {{XLEN{1'b0}}, a_mag};
                opnd <= b_mag;
              end
            end
          end
        end
        CALC: begin
          acc <= acc_step;
          if (cnt == CNT_LAST || flush) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
          if (cnt == CNT_LAST) resp_result <= fix_res;
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
